muldiv_ctrl: RTL and testbench

Sequencer and state holder for the MIPS HI/LO multiply/divide resource. Accepts MULT/MULTU/DIV/DIVU from the R-type decode stage, runs an iterative 1-bit-per-cycle shift-add/restoring-divide engine, and owns the HI/LO registers. Serves MFHI/MFLO/MTHI/MTLO and raises a stall to the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'd16;
  localparam logic [5:0] FUNC_MTHI  = 6'd17;
  localparam logic [5:0] FUNC_MFLO  = 6'd18;
  localparam logic [5:0] FUNC_MTLO  = 6'd19;
  localparam logic [5:0] FUNC_MULT  = 6'd24;
  localparam logic [5:0] FUNC_MULTU = 6'd25;
  localparam logic [5:0] FUNC_DIV   = 6'd26;
  localparam logic [5:0] FUNC_DIVU  = 6'd27;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;

  function automatic logic is_recognised(input logic [5:0] code);
    case (code)
      FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
      FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the decode stage and the HI/LO unit.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             i_con_start;
  logic [5:0]       i_con_FuncCode;
  logic             i_con_flush;
  logic [WIDTH-1:0] i_rs;
  logic [WIDTH-1:0] i_rt;
  logic             o_con_busy;
  logic             o_con_stall;
  logic             o_con_done;
  logic [WIDTH-1:0] o_rdata;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_con_start, i_con_FuncCode, i_con_flush, i_rs, i_rt,
    input  o_con_busy, o_con_stall, o_con_done, o_rdata, o_hi, o_lo
  );

  modport slave (
    input  i_con_start, i_con_FuncCode, i_con_flush, i_rs, i_rt,
    output o_con_busy, o_con_stall, o_con_done, o_rdata, o_hi, o_lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator. Multiply holds {partial, multiplier}; divide holds {remainder, quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t                op_type,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_fits;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_fits  = rem_shift >= {1'b0, operand};
    // Remainder stays below the divisor, so a successful trial fits in WIDTH bits.
    rem_diff  = rem_shift[WIDTH-1:0] - operand;
    acc_next  = '0;
    if (op_type == OP_MUL)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (rem_fits)
      acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, sign fix-up and
// the architectural HI/LO registers.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      i_clk,
  input logic      i_rst,
  muldiv_if.slave  mdu
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  op_t                op_type;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   operand, rs_saved, hi, lo;
  logic [WIDTH-1:0]   fix_hi, fix_lo, abs_rs, abs_rt;
  logic               neg_result, neg_rem, div_zero;
  logic               is_arith, is_signed, is_div;
  logic               load, commit, write_hi, write_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_type  (op_type),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  always_comb begin
    is_arith  = mdu.i_con_FuncCode inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
    is_signed = mdu.i_con_FuncCode inside {FUNC_MULT, FUNC_DIV};
    is_div    = mdu.i_con_FuncCode inside {FUNC_DIV, FUNC_DIVU};
    abs_rs    = (is_signed && mdu.i_rs[WIDTH-1]) ? -mdu.i_rs : mdu.i_rs;
    abs_rt    = (is_signed && mdu.i_rt[WIDTH-1]) ? -mdu.i_rt : mdu.i_rt;
  end

  // Flush beats any same-cycle request, including MTHI/MTLO.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    commit     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (mdu.i_con_start && !mdu.i_con_flush) begin
          if (is_arith) begin
            load       = 1'b1;
            state_next = RUN;
          end
          write_hi = (mdu.i_con_FuncCode == FUNC_MTHI);
          write_lo = (mdu.i_con_FuncCode == FUNC_MTLO);
        end
      end
      RUN: begin
        if (mdu.i_con_flush)
          state_next = IDLE;
        else if (count == '0)
          state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        commit     = !mdu.i_con_flush;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod   = neg_result ? -acc : acc;
    fix_hi = '0;
    fix_lo = '0;
    if (op_type == OP_MUL) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = rs_saved;
      fix_lo = '1;
    end else begin
      fix_lo = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      op_type    <= OP_MUL;
      count      <= '0;
      acc        <= '0;
      operand    <= '0;
      rs_saved   <= '0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        op_type    <= is_div ? OP_DIV : OP_MUL;
        acc        <= {{WIDTH{1'b0}}, (is_div ? abs_rs : abs_rt)};
        operand    <= is_div ? abs_rt : abs_rs;
        rs_saved   <= mdu.i_rs;
        neg_result <= is_signed && (mdu.i_rs[WIDTH-1] ^ mdu.i_rt[WIDTH-1]);
        neg_rem    <= is_signed && mdu.i_rs[WIDTH-1];
        div_zero   <= is_div && (mdu.i_rt == '0);
        count      <= CNT_W'(WIDTH - 1);
      end else if (state == RUN) begin
        acc   <= acc_step;
        count <= count - 1'b1;
      end
      if (write_hi) hi <= mdu.i_rs;
      if (write_lo) lo <= mdu.i_rs;
      if (commit) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

  assign mdu.o_con_busy  = (state != IDLE);
  assign mdu.o_con_stall = (state != IDLE) && mdu.i_con_start && is_recognised(mdu.i_con_FuncCode);
  assign mdu.o_con_done  = commit;
  assign mdu.o_hi        = hi;
  assign mdu.o_lo        = lo;
  assign mdu.o_rdata     = (mdu.i_con_FuncCode == FUNC_MFHI) ? hi :
                           (mdu.i_con_FuncCode == FUNC_MFLO) ? lo : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int DONE_CYCLE = WIDTH + 1;

  typedef struct {
    string       name;
    logic [5:0]  fc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mdu   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [5:0] fc,
                               input logic [31:0] rs, input logic [31:0] rt, input logic flush);
    bus.i_con_start    = start;
    bus.i_con_FuncCode = fc;
    bus.i_rs           = rs;
    bus.i_rt           = rt;
    bus.i_con_flush    = flush;
  endtask

  function automatic void refModel(input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa, sb, q, r;
    hi = '0;
    lo = '0;
    p  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fc)
      FUNC_MULT: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      FUNC_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      FUNC_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      FUNC_DIVU: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Caller sits just after a negedge (cycle 0); returns just after the negedge
  // of the cycle following done, or after the budget with done_cycle = -1.
  task automatic runOp(input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b,
                       output int done_cycle);
    applyStimulus(1'b1, fc, a, b, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    done_cycle = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      #1;
      if (cyc == 1) checkOutput("busy_cycle1", 32'(bus.o_con_busy), 32'd1);
      if (bus.o_con_done && done_cycle < 0) done_cycle = cyc;
      @(negedge clk);
      if (done_cycle >= 0) break;
    end
  endtask

  vec_t        vecs[8];
  int          done_cycle;
  int          stall_cnt;
  int          done_seen;
  logic [31:0] exp_hi, exp_lo, lo_before;
  logic [5:0]  rand_fc;
  logic [31:0] ra, rb;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"multu_max",   FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_neg",    FUNC_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_neg",     FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_zero",   FUNC_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{"div_wrap",    FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"div_negdiv",  FUNC_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div_zero_sg", FUNC_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"multu_zero",  FUNC_MULTU, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    // Reset, with a request pending to show reset dominates.
    rst = 1'b1;
    applyStimulus(1'b1, FUNC_MULT, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_hi", bus.o_hi, 32'd0);
    checkOutput("reset_lo", bus.o_lo, 32'd0);
    checkOutput("reset_busy", 32'(bus.o_con_busy), 32'd0);
    checkOutput("reset_stall", 32'(bus.o_con_stall), 32'd0);
    checkOutput("reset_done", 32'(bus.o_con_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);

    foreach (vecs[i]) begin
      runOp(vecs[i].fc, vecs[i].rs, vecs[i].rt, done_cycle);
      #1;
      checkOutput({vecs[i].name, "_done_cycle"}, 32'(done_cycle), 32'(DONE_CYCLE));
      checkOutput({vecs[i].name, "_hi"}, bus.o_hi, vecs[i].hi);
      checkOutput({vecs[i].name, "_lo"}, bus.o_lo, vecs[i].lo);
      checkOutput({vecs[i].name, "_idle"}, 32'(bus.o_con_busy), 32'd0);
    end

    // Moves to/from HI/LO.
    applyStimulus(1'b1, FUNC_MTHI, 32'hCAFE_BABE, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MTLO, 32'h0BAD_F00D, '0, 1'b0);
    #1;
    checkOutput("mthi_hi", bus.o_hi, 32'hCAFE_BABE);
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MFHI, '0, '0, 1'b0);
    #1;
    checkOutput("mtlo_lo", bus.o_lo, 32'h0BAD_F00D);
    checkOutput("mfhi_rdata", bus.o_rdata, 32'hCAFE_BABE);
    applyStimulus(1'b1, FUNC_MFLO, '0, '0, 1'b0);
    #1;
    checkOutput("mflo_rdata", bus.o_rdata, 32'h0BAD_F00D);
    applyStimulus(1'b1, FUNC_DIVU + 6'd1, '0, '0, 1'b0);
    #1;
    checkOutput("rdata_other", bus.o_rdata, 32'd0);
    @(negedge clk);
    checkOutput("unknown_no_busy", 32'(bus.o_con_busy), 32'd0);

    // Stall while busy: requester holds MFLO until it is accepted.
    applyStimulus(1'b1, FUNC_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MFLO, '0, '0, 1'b0);
    stall_cnt = 0;
    for (int cyc = 1; cyc <= DONE_CYCLE; cyc++) begin
      #1;
      if (bus.o_con_stall) stall_cnt++;
      @(negedge clk);
    end
    #1;
    checkOutput("stall_cycles", 32'(stall_cnt), 32'(DONE_CYCLE));
    checkOutput("stall_released", 32'(bus.o_con_stall), 32'd0);
    checkOutput("stall_mflo_rdata", bus.o_rdata, 32'hFFFF_FFEB);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);

    // Flush during RUN.
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MTHI, 32'h1234_5678, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    #1;
    checkOutput("flush_mthi", bus.o_hi, 32'h1234_5678);
    lo_before = bus.o_lo;
    applyStimulus(1'b1, FUNC_MULTU, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    done_seen = 0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      #1;
      if (bus.o_con_done) done_seen++;
      @(negedge clk);
    end
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b1);
    #1;
    checkOutput("flush_busy_before", 32'(bus.o_con_busy), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    #1;
    checkOutput("flush_busy_after", 32'(bus.o_con_busy), 32'd0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (bus.o_con_done) done_seen++;
      @(negedge clk);
    end
    checkOutput("flush_no_done", 32'(done_seen), 32'd0);
    checkOutput("flush_hi", bus.o_hi, 32'h1234_5678);
    checkOutput("flush_lo", bus.o_lo, lo_before);

    // Reset in RUN cycle 20.
    applyStimulus(1'b1, FUNC_MULT, 32'd123, 32'd456, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.o_con_busy), 32'd0);
    checkOutput("midrst_hi", bus.o_hi, 32'd0);
    checkOutput("midrst_lo", bus.o_lo, 32'd0);

    // Flush wins over a same-cycle start in IDLE.
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MTLO, 32'hDEAD_BEEF, '0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, FUNC_MULT, 32'd3, 32'd3, 1'b1);
    #1;
    checkOutput("flush_mtlo_ignored", bus.o_lo, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 6'd0, '0, '0, 1'b0);
    #1;
    checkOutput("flush_mult_ignored", 32'(bus.o_con_busy), 32'd0);
    @(negedge clk);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       rand_fc = FUNC_MULT;
        1:       rand_fc = FUNC_MULTU;
        2:       rand_fc = FUNC_DIV;
        default: rand_fc = FUNC_DIVU;
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
        2:       rb = -($urandom_range(1, 9));
        default: ;
      endcase
      refModel(rand_fc, ra, rb, exp_hi, exp_lo);
      runOp(rand_fc, ra, rb, done_cycle);
      #1;
      checkOutput($sformatf("rand%0d_done_cycle", n), 32'(done_cycle), 32'(DONE_CYCLE));
      checkOutput($sformatf("rand%0d_fc%0d_%08h_%08h_hi", n, rand_fc, ra, rb), bus.o_hi, exp_hi);
      checkOutput($sformatf("rand%0d_fc%0d_%08h_%08h_lo", n, rand_fc, ra, rb), bus.o_lo, exp_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
